// File: rtl/tile_spawner.sv
// Spawns a new 2 (or 4 with TILE_SPAWNER_FOUR_EN) tile into an empty board cell found by an
// LFSR-seeded wrapping scan; reports full when every cell is occupied.
module tile_spawner #(
   parameter logic [15:0] SEED = 16'hACE1
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   start,
   input  logic [3:0][3:0][11:0]  board_in,
   output logic [3:0][3:0][11:0]  board_out,
   output logic                   busy,
   output logic                   done,
   output logic                   full,
   output logic [1:0]             spawn_row,
   output logic [1:0]             spawn_col,
   output logic [11:0]            spawn_val
);

   localparam logic [15:0] LFSR_INIT = (SEED == 16'h0000) ? 16'h0001 : SEED;

   typedef enum logic [1:0] {IDLE, SCAN, DONE} state_t;

   state_t                 state_reg, state_next;
   logic [15:0]            lfsr_reg;
   logic                   lfsr_fb;
   logic [3:0]             pos_reg, cnt_reg;
   logic [11:0]            tile_reg, tile_value;
   logic                   full_reg;
   logic [1:0]             row_reg, col_reg;
   logic [11:0]            val_reg;
   logic [3:0][3:0][11:0]  board_reg;
   logic                   accept, cell_empty, hit, give_up;

   // Taps 16,14,13,11 in 1-based numbering.
   assign lfsr_fb = lfsr_reg[15] ^ lfsr_reg[13] ^ lfsr_reg[12] ^ lfsr_reg[10];

   always_ff @(posedge clk or posedge rst) begin
      if (rst) lfsr_reg <= LFSR_INIT;
      else     lfsr_reg <= {lfsr_reg[14:0], lfsr_fb};
   end

`ifdef TILE_SPAWNER_FOUR_EN
   assign tile_value = (lfsr_reg[15:13] == 3'b000) ? 12'd4 : 12'd2;
`else
   assign tile_value = 12'd2;
`endif

   assign accept     = (state_reg == IDLE) && start;
   assign cell_empty = (board_reg[pos_reg[3:2]][pos_reg[1:0]] == 12'd0);
   assign hit        = (state_reg == SCAN) && cell_empty;
   assign give_up    = (state_reg == SCAN) && !cell_empty && (cnt_reg == 4'd15);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state_reg <= IDLE;
      else     state_reg <= state_next;
   end

   always_comb begin
      state_next = state_reg;
      case (state_reg)
         IDLE:    if (start) state_next = SCAN;
         SCAN:    if (cell_empty || cnt_reg == 4'd15) state_next = DONE;
         DONE:    state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         pos_reg  <= '0;
         cnt_reg  <= '0;
         tile_reg <= '0;
      end else if (accept) begin
         pos_reg  <= lfsr_reg[3:0];
         cnt_reg  <= '0;
         tile_reg <= tile_value;
      end else if (state_reg == SCAN && !cell_empty) begin
         pos_reg  <= pos_reg + 4'd1;
         cnt_reg  <= cnt_reg + 4'd1;
      end
   end

   // Result registers are only touched at scan completion so they hold across idle periods.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         full_reg <= 1'b0;
         row_reg  <= '0;
         col_reg  <= '0;
         val_reg  <= '0;
      end else if (hit) begin
         full_reg <= 1'b0;
         row_reg  <= pos_reg[3:2];
         col_reg  <= pos_reg[1:0];
         val_reg  <= tile_reg;
      end else if (give_up) begin
         full_reg <= 1'b1;
         val_reg  <= '0;
      end
   end

   genvar gi;
   generate
      for (gi = 0; gi < 16; gi++) begin : g_cell
         logic [11:0] cell_reg;
         always_ff @(posedge clk or posedge rst) begin
            if (rst)                               cell_reg <= '0;
            else if (accept)                       cell_reg <= board_in[gi/4][gi%4];
            else if (hit && pos_reg == 4'(gi))     cell_reg <= tile_reg;
         end
         assign board_reg[gi/4][gi%4] = cell_reg;
      end
   endgenerate

   assign board_out = board_reg;
   assign busy      = (state_reg != IDLE);
   assign done      = (state_reg == DONE);
   assign full      = full_reg;
   assign spawn_row = row_reg;
   assign spawn_col = col_reg;
   assign spawn_val = val_reg;

endmodule
